regfile_sb_bypass: RTL

Parametrised successor to the CPU general-purpose register file. It provides:
- two combinational read ports and one synchronous write port;
- optional hardwired zero register and write-through bypass;
- a per-register pending-write scoreboard for hazard detection in the pipelined core;
- a multi-cycle clear sequencer.

It sits between decode (reads, pending marks) and writeback (writes, scoreboard release).

---
 rtl/regfile_sb_bypass.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_sb_bypass.sv
// Register file with optional hardwired zero register, write-through bypass,
// a per-register pending-write scoreboard and a multi-cycle clear sweep.
module regfile_sb_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_ready,
  output logic              rt_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pend_en,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic              clr_req,
  output logic              clr_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             idx;
  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [DEPTH-1:0]              busy;

  logic idle, wrOk, pendOk;
  logic hitS, hitT, zeroS, zeroT;

  // Register 0 is read-only when hardwired to zero.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes and pending marks are only honoured outside the clear sweep.
  always_comb begin
    idle   = (state == IDLE);
    wrOk   = wr_en && idle && writable(wr_addr);
    pendOk = pend_en && idle && writable(pend_addr);
  end

  // Read ports: bypass beats the array, zero register beats both.
  always_comb begin
    hitS  = (BYPASS != 0) && wrOk && (wr_addr == rs_addr);
    hitT  = (BYPASS != 0) && wrOk && (wr_addr == rt_addr);
    zeroS = (ZERO_REG != 0) && (rs_addr == '0);
    zeroT = (ZERO_REG != 0) && (rt_addr == '0);

    if (hitS)       rs_data = wr_data;
    else if (zeroS) rs_data = '0;
    else            rs_data = regs[rs_addr];

    if (hitT)       rt_data = wr_data;
    else if (zeroT) rt_data = '0;
    else            rt_data = regs[rt_addr];

    // Nothing is final while the sweep is rewriting the array.
    rs_ready = idle && (zeroS || hitS || !busy[rs_addr]);
    rt_ready = idle && (zeroT || hitT || !busy[rt_addr]);
  end

  // Array, scoreboard and clear sequencer; the pending set is applied after
  // the writeback release so a newer producer keeps the register busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs     <= '0;
      busy     <= '0;
      state    <= IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wrOk) begin
            regs[wr_addr] <= wr_data;
            busy[wr_addr] <= 1'b0;
          end
          if (pendOk) busy[pend_addr] <= 1'b1;
          if (clr_req) begin
            state    <= CLEAR;
            idx      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          regs[idx] <= '0;
          busy[idx] <= 1'b0;
          idx       <= idx + ADDR_W'(1);
          if (&idx) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
